// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   UART_DATA_W  - payload width of one frame
//   uart_state_t - frame FSM state encoding (IDLE/START/DATA/STOP)
//   tx_fsm_t     - transmitter FSM register bundle (state plus its counters),
//                  kept together so checkers can bind to one named signal
//   length_baud  - clk cycles per bit, one common definition for TX and RX
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  typedef struct packed {
    uart_state_t state;
    logic [2:0]  bit_idx;   // data bit currently on the line, 0..7
    logic        stop_cnt;  // stop bit currently on the line, 0..1
  } tx_fsm_t;

  function automatic int length_baud(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter.
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, counter to 0
//   clear - synchronous clear, holds the counter at 0 while high
//   tick  - high in the last cycle of a bit period (count == LENGTH_BAUD-1);
//           the counter wraps to 0 on the following edge
module uart_baud_gen #(
  parameter int LENGTH_BAUD = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (LENGTH_BAUD > 1) ? $clog2(LENGTH_BAUD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH_BAUD - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_txd.sv
// uart_txd: UART transmitter, 8 data bits, no parity, 1 or 2 stop bits.
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset; aborts any frame in flight
//   data_i  - byte to send, sampled only on handshake
//   valid_i - data_i holds a valid byte
//   ready_o - holding buffer empty
//   busy_o  - a frame is on the line (registered, aligned with txd)
//   done_o  - one-cycle pulse in the last cycle of the final stop bit
//   txd     - serial line, registered, idles high
//
// Handshake: a byte is taken when valid_i && ready_o at a rising edge. The
// byte lands in a one-deep holding buffer, so the host can queue the next
// byte while the current frame is still shifting out; valid_i held while
// ready_o is low changes nothing.
module uart_txd
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int STOP_BITS       = 1,
  parameter int MSB_FIRST       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   txd
);

  localparam int LENGTH_BAUD = length_baud(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if (LENGTH_BAUD < 2) begin : g_bad_baud
    $error("uart_txd: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_txd: STOP_BITS must be 1 or 2");
  end

  tx_fsm_t                fsm;
  logic [UART_DATA_W-1:0] hold_q;
  logic                   hold_full;
  logic [UART_DATA_W-1:0] shreg;
  logic                   baud_tick;
  logic                   cur_bit;

  assign ready_o = ~hold_full;
  assign cur_bit = (MSB_FIRST != 0) ? shreg[UART_DATA_W-1] : shreg[0];

  // Held at zero while idle so the start bit always gets a full period.
  uart_baud_gen #(
    .LENGTH_BAUD(LENGTH_BAUD)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(fsm.state == ST_IDLE),
    .tick (baud_tick)
  );

  // txd and busy_o are registered from the current state, so the line lags
  // the FSM by one cycle: accept at edge N, state START at N+1, txd low at N+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm.state    <= ST_IDLE;
      fsm.bit_idx  <= '0;
      fsm.stop_cnt <= 1'b0;
      hold_q       <= '0;
      hold_full    <= 1'b0;
      shreg        <= '0;
      txd          <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      // ready_o is low whenever the buffer drains below, so an accept and a
      // drain never land on the same edge.
      if (valid_i && ready_o) begin
        hold_q    <= data_i;
        hold_full <= 1'b1;
      end

      busy_o <= (fsm.state != ST_IDLE);
      done_o <= 1'b0;

      case (fsm.state)
        ST_START: txd <= 1'b0;
        ST_DATA:  txd <= cur_bit;
        default:  txd <= 1'b1;
      endcase

      case (fsm.state)
        ST_IDLE: begin
          if (hold_full) begin
            fsm.state <= ST_START;
            shreg     <= hold_q;
            hold_full <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            fsm.state   <= ST_DATA;
            fsm.bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shreg <= (MSB_FIRST != 0) ? {shreg[UART_DATA_W-2:0], 1'b0}
                                      : {1'b0, shreg[UART_DATA_W-1:1]};
            if (fsm.bit_idx == 3'd7) begin
              fsm.state    <= ST_STOP;
              fsm.stop_cnt <= 1'b0;
            end else begin
              fsm.bit_idx <= fsm.bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (fsm.stop_cnt == STOP_LAST) begin
              done_o <= 1'b1;
              // A queued byte starts on the very next cycle: no idle gap.
              if (hold_full) begin
                fsm.state <= ST_START;
                shreg     <= hold_q;
                hold_full <= 1'b0;
              end else begin
                fsm.state <= ST_IDLE;
              end
            end else begin
              fsm.stop_cnt <= 1'b1;
            end
          end
        end
        default: fsm.state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txd.sv
// tb_uart_txd: directed bench for uart_txd with LENGTH_BAUD = 10.
// Instance 0: MSB first, 1 stop bit. Instance 1: LSB first, 2 stop bits.
// Accepted bytes go into per-instance expected queues; a line monitor per
// instance decodes each frame from txd and pops/compares.
module tb_uart_txd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] valid_v;
  logic [1:0] ready_v;
  logic [1:0] busy_v;
  logic [1:0] done_v;
  logic [1:0] txd_v;
  logic [7:0] data_v [2];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_txd #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1), .MSB_FIRST(1)
  ) dut0 (
    .clk(clk), .rst(rst), .data_i(data_v[0]), .valid_i(valid_v[0]),
    .ready_o(ready_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]), .txd(txd_v[0])
  );

  uart_txd #(
    .CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2), .MSB_FIRST(0)
  ) dut1 (
    .clk(clk), .rst(rst), .data_i(data_v[1]), .valid_i(valid_v[1]),
    .ready_o(ready_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]), .txd(txd_v[1])
  );

  // ---------------- check helpers ----------------
  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic checki(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      tests++;
      fails++;
      $display("FAIL wait_edge: at cycle %0d wanted %0d", cyc, k);
    end
  endtask

  // ---------------- driver ----------------
  // Offers b; with junk=1 the data bus changes every cycle while ready is low.
  // Returns the accepting edge number (cyc after that edge).
  task automatic send(input int i, input logic [7:0] b, input bit junk, output int acc);
    int guard;
    guard = 0;
    valid_v[i] = 1'b1;
    while (!ready_v[i] && guard < 400) begin
      data_v[i] = junk ? (8'(cyc) ^ 8'h5A) : b;
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: inst %0d ready stuck at %0b", i, ready_v[i]);
      valid_v[i] = 1'b0;
      acc = cyc;
      return;
    end
    data_v[i] = b;
    if (i == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
    @(posedge clk);
    #1;
    acc        = cyc;
    valid_v[i] = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && guard < 1500) begin
      @(negedge clk);
      guard++;
    end
    checki("drain_q0", exp_q0.size(), 0);
    checki("drain_q1", exp_q1.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Entered at the negedge showing the first start-bit cycle.
  task automatic mon_frame(input int i);
    logic [7:0] got;
    logic [7:0] exp;
    logic       bit_v;
    int         bad;
    int         empty;
    int         sb;
    bit         msbf;
    sb    = (i == 0) ? 1 : 2;
    msbf  = (i == 0);
    bad   = 0;
    empty = 0;
    got   = '0;
    exp   = '0;
    bit_v = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (rst) return;
      if (txd_v[i] !== 1'b0) bad = 1;
    end
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (rst) return;
        if (c == 0) bit_v = txd_v[i];
        else if (txd_v[i] !== bit_v) bad = 2;
      end
      if (msbf) got[7-b] = bit_v;
      else      got[b]   = bit_v;
    end
    for (int c = 0; c < 10 * sb; c++) begin
      @(negedge clk);
      if (rst) return;
      if (txd_v[i] !== 1'b1) bad = 3;
    end
    tests++;
    if (i == 0) begin
      if (exp_q0.size() > 0) exp = exp_q0.pop_front(); else empty = 1;
    end else begin
      if (exp_q1.size() > 0) exp = exp_q1.pop_front(); else empty = 1;
    end
    if (empty != 0 || bad != 0 || got !== exp) begin
      fails++;
      $display("FAIL frame%0d: got %02h expected %02h (shape_err=%0d queue_empty=%0d)",
               i, got, exp, bad, empty);
    end
  endtask

  always begin
    @(negedge clk);
    if (!rst && txd_v[0] === 1'b0) mon_frame(0);
  end

  always begin
    @(negedge clk);
    if (!rst && txd_v[1] === 1'b0) mon_frame(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int   n;
    int   m;
    int   d1;
    int   d2;
    int   busy_low;
    int   guard;
    logic t_after;

    valid_v   = '0;
    data_v[0] = '0;
    data_v[1] = '0;
    t_after   = 1'b1;

    // Reset with a byte offered: nothing may be accepted or framed.
    #1 rst = 1'b1;
    valid_v   = 2'b11;
    data_v[0] = 8'hFF;
    data_v[1] = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check1("rst_txd",   txd_v[i],   1'b1);
        check1("rst_ready", ready_v[i], 1'b1);
        check1("rst_busy",  busy_v[i],  1'b0);
        check1("rst_done",  done_v[i],  1'b0);
      end
    end
    valid_v = '0;
    rst     = 1'b0;
    repeat (3) @(negedge clk);
    check1("post_rst_txd0",  txd_v[0],  1'b1);
    check1("post_rst_busy0", busy_v[0], 1'b0);
    check1("post_rst_txd1",  txd_v[1],  1'b1);

    // Single byte A5, MSB first: bits 1,0,1,0,0,1,0,1.
    send(0, 8'hA5, 1'b0, n);
    check1("a5_ready_drop", ready_v[0], 1'b0);
    wait_edge(n + 1);
    check1("a5_latency_txd",  txd_v[0],   1'b1);
    check1("a5_latency_busy", busy_v[0],  1'b0);
    check1("a5_ready_back",   ready_v[0], 1'b1);
    wait_edge(n + 2);
    check1("a5_start_first", txd_v[0],  1'b0);
    check1("a5_busy_up",     busy_v[0], 1'b1);
    wait_edge(n + 11);
    check1("a5_start_last", txd_v[0], 1'b0);
    wait_edge(n + 12);
    check1("a5_bit7", txd_v[0], 1'b1);
    wait_edge(n + 22);
    check1("a5_bit6", txd_v[0], 1'b0);
    wait_edge(n + 52);
    check1("a5_bit3", txd_v[0], 1'b0);
    wait_edge(n + 91);
    check1("a5_bit0_last", txd_v[0], 1'b1);
    wait_edge(n + 92);
    check1("a5_stop_first", txd_v[0], 1'b1);
    check1("a5_done_early", done_v[0], 1'b0);
    wait_edge(n + 100);
    check1("a5_done_pre", done_v[0], 1'b0);
    wait_edge(n + 101);
    check1("a5_done",      done_v[0], 1'b1);
    check1("a5_stop_last", txd_v[0],  1'b1);
    check1("a5_busy_last", busy_v[0], 1'b1);
    wait_edge(n + 102);
    check1("a5_done_off", done_v[0], 1'b0);
    check1("a5_busy_off", busy_v[0], 1'b0);

    // Back-to-back 55 then 0F, second offered mid-DATA.
    send(0, 8'h55, 1'b0, n);
    wait_edge(n + 30);
    send(0, 8'h0F, 1'b0, m);
    d1 = -1;
    d2 = -1;
    busy_low = 0;
    guard = 0;
    while (d2 < 0 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (busy_v[0] !== 1'b1) busy_low++;
      if (d1 >= 0 && cyc == d1 + 1) t_after = txd_v[0];
      if (done_v[0] === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else        d2 = cyc;
      end
    end
    checki("b2b_done1_edge", d1, n + 101);
    checki("b2b_done_gap",   d2 - d1, 100);
    checki("b2b_busy_drops", busy_low, 0);
    check1("b2b_next_start", t_after, 1'b0);

    // Backpressure: junk on the bus while the buffer is full.
    send(0, 8'h3C, 1'b1, n);
    send(0, 8'h81, 1'b1, m);
    check1("bp_ready_full", ready_v[0], 1'b0);
    send(0, 8'hE7, 1'b1, m);
    drain();

    // LSB first, two stop bits, byte 01: 110-cycle frame.
    send(1, 8'h01, 1'b0, n);
    wait_edge(n + 2);
    check1("lsb_start", txd_v[1], 1'b0);
    wait_edge(n + 12);
    check1("lsb_bit0", txd_v[1], 1'b1);
    wait_edge(n + 21);
    check1("lsb_bit0_end", txd_v[1], 1'b1);
    wait_edge(n + 22);
    check1("lsb_bit1", txd_v[1], 1'b0);
    wait_edge(n + 91);
    check1("lsb_bit7", txd_v[1], 1'b0);
    wait_edge(n + 101);
    check1("lsb_stop_mid",  txd_v[1],  1'b1);
    check1("lsb_done_mid",  done_v[1], 1'b0);
    wait_edge(n + 111);
    check1("lsb_done",      done_v[1], 1'b1);
    check1("lsb_busy_last", busy_v[1], 1'b1);
    wait_edge(n + 112);
    check1("lsb_busy_off", busy_v[1], 1'b0);
    check1("lsb_done_off", done_v[1], 1'b0);
    drain();

    // Mid-frame reset during data bit 3 of C3.
    send(0, 8'hC3, 1'b0, n);
    wait_edge(n + 45);
    check1("c3_bit3", txd_v[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    check1("mrst_txd",   txd_v[0],   1'b1);
    check1("mrst_ready", ready_v[0], 1'b1);
    check1("mrst_busy",  busy_v[0],  1'b0);
    repeat (2) @(negedge clk);
    exp_q0.delete();
    rst = 1'b0;
    @(negedge clk);
    check1("mrst_ready_after", ready_v[0], 1'b1);
    check1("mrst_txd_after",   txd_v[0],   1'b1);
    send(0, 8'h5A, 1'b0, n);
    wait_edge(n + 2);
    check1("mrst_next_start", txd_v[0], 1'b0);
    wait_edge(n + 12);
    check1("mrst_next_bit7", txd_v[0], 1'b0);
    wait_edge(n + 22);
    check1("mrst_next_bit6", txd_v[0], 1'b1);
    drain();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_txd.md
Name: uart_txd

Overview:
- UART transmitter; the transmit-side companion of the team's UART receiver.
- Serialises 8-bit bytes as 8N1 frames, with a configurable number of stop bits, onto the txd line.
- Host side is a valid/ready byte interface with a one-deep holding buffer, so consecutive bytes go out back-to-back with no idle gap.
- Sits between the command/data producer and the board TX pin.

Parameters:
- CLOCK_FREQUENCY, 100_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in baud. LENGTH_BAUD = CLOCK_FREQUENCY / BAUD_RATE (integer division) clk cycles per bit.
- STOP_BITS, 1, number of stop bits (1 or 2).
- MSB_FIRST, 1, bit order. 1 sends data_i[7] first, matching the team receiver's shift direction. 0 sends data_i[0] first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  8  byte to send; sampled only on handshake.
- valid_i  in  1  data_i holds a valid byte.
- ready_o  out  1  holding buffer empty; byte accepted when valid_i && ready_o at a rising edge.
- busy_o  out  1  a frame is on the line (state != IDLE).
- done_o  out  1  one-cycle pulse in the last cycle of the final stop bit.
- txd  out  1  serial line, registered, idles high.

Behaviour:
- Reset (async, rst=1): txd=1, ready_o=1, busy_o=0, done_o=0, state=IDLE, buffer empty, counters cleared. Asserting rst mid-frame aborts the frame immediately; txd returns high on reset assertion.
- Handshake: accept when valid_i && ready_o. The byte goes into the holding buffer and ready_o drops the next cycle. ready_o rises the cycle after the FSM moves the buffer into the shift register.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START: when the buffer is full. The buffer moves to the shift register in the same cycle.
  - Byte accepted at edge N while IDLE: txd=0 from edge N+2. Fixed latency of 2 cycles from accept to start-bit edge.
- Bit timing: baud counter runs 0..LENGTH_BAUD-1. Every bit (start, data, stop) lasts exactly LENGTH_BAUD cycles. The state or bit advances when the counter is LENGTH_BAUD-1, and the counter wraps to 0.
- START: txd=0 for one bit, then DATA with bit index 0.
- DATA: txd = current bit, in MSB_FIRST order. Bit index counts 0..7; after index 7 ends, go to STOP.
- STOP: txd=1 for STOP_BITS*LENGTH_BAUD cycles. done_o=1 in the final cycle.
  - If the buffer is full at that edge, go directly to START. The next start bit immediately follows the stop bit, with zero idle cycles.
  - Otherwise go to IDLE.
- Buffer: a byte may be accepted while a frame is in flight; this is what makes back-to-back frames possible. valid_i held with ready_o=0 causes no data change.
- Simultaneous events: in the cycle the buffer empties into the shift register, ready_o is still 0. A new accept is therefore not possible in that cycle; no collision.
- busy_o=1 from the first START cycle through the last STOP cycle. Across back-to-back frames it stays 1 continuously.
- Widths: baud counter is $clog2(LENGTH_BAUD) bits; bit index is 3 bits; stop counter is 1 bit.
- Elaboration error if LENGTH_BAUD < 2 or STOP_BITS not in {1,2}.

Decomposition:
- Shared package uart_pkg:
  - function length_baud(CLOCK_FREQUENCY, BAUD_RATE).
  - state encoding constants (ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3).
  - UART_DATA_W=8.
  - Reused by the receiver for a common LENGTH_BAUD definition.
- One natural sub-module: uart_baud_gen. Free-running counter with a synchronous clear and a tick output at LENGTH_BAUD-1. Shareable with the receiver.
- FSM, holding buffer and shift register stay in uart_txd.

Test Plan (sim with CLOCK_FREQUENCY=1_000_000, BAUD_RATE=100_000, so LENGTH_BAUD=10):
- Reset: assert rst for 3 cycles with valid_i=1, data_i=8'hFF -> txd=1, ready_o=1, busy_o=0, done_o=0 throughout; no frame starts before rst deasserts.
- Single byte 8'hA5, MSB_FIRST=1: accept at edge N -> txd=0 over cycles N+2..N+11; data bits 1,0,1,0,0,1,0,1 at 10 cycles each; stop high 10 cycles; done_o high exactly at cycle N+101; busy_o low at N+102.
- Back-to-back 8'h55 then 8'h0F (second offered while the first is in DATA) -> second start bit begins the cycle after the first frame's last stop cycle; busy_o never drops; done_o pulses twice, 100 cycles apart.
- Backpressure: hold valid_i=1 with data_i changing each cycle while the buffer is full -> ready_o=0; only the byte present at the accepting edge is transmitted; the transmitted sequence equals the accepted sequence.
- Bit order and stop bits: MSB_FIRST=0, STOP_BITS=2, byte 8'h01 -> first data bit=1, then seven 0s; stop high 20 cycles; frame length 110 cycles.
- Mid-frame reset: assert rst during data bit 3 of 8'hC3 -> txd=1 at once; ready_o=1 after release; the next accepted byte is framed correctly from its start bit.
